// File: rtl/cond_logic.sv
// Conditional-execution unit: evaluates the instruction condition against the
// registered NZCV flags and gates the decoder's write strobes and flag updates.
module cond_logic #(
  parameter logic [3:0] FLAGS_INIT = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  input  logic       Stall,
  input  logic       Flush,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  logic [3:0] r_flags;
  logic       w_condex;
  logic       w_valid;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic res;
    {n, z, c, v} = nzcv;
    case (cond)
      4'b0000: res = z;
      4'b0001: res = !z;
      4'b0010: res = c;
      4'b0011: res = !c;
      4'b0100: res = n;
      4'b0101: res = !n;
      4'b0110: res = v;
      4'b0111: res = !v;
      4'b1000: res = c & !z;
      4'b1001: res = !c | z;
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = !z & (n == v);
      4'b1101: res = z | (n != v);
      4'b1110: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Condition is judged on the pre-edge flags; no bypass of this cycle's ALUFlags.
  assign w_condex = cond_pass(Cond, r_flags);
  assign w_valid  = w_condex & !Stall & !Flush & reset;

  assign CondEx   = w_condex;
  assign PCSrc    = PCS & w_valid;
  assign RegWrite = RegW & !NoWrite & w_valid;
  assign MemWrite = MemW & w_valid;
  assign Flags    = r_flags;

  // N,Z and C,V halves are written independently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= FLAGS_INIT;
    end else if (w_valid) begin
      if (FlagW[1]) r_flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) r_flags[1:0] <= ALUFlags[1:0];
    end
  end

endmodule

// File: doc/cond_logic.md
COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 Parameter: FLAGS_INIT, default 4'b0000, NZCV value loaded into the flag register on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 Cond  input  4  instruction condition field [31:28].
REQ-005 ALUFlags  input  4  NZCV from ALU this cycle (bit3=N, bit2=Z, bit1=C, bit0=V).
REQ-006 FlagW  input  2  flag write request: bit1 -> N,Z; bit0 -> C,V.
REQ-007 PCS  input  1  decoder request to write PC.
REQ-008 RegW  input  1  decoder request to write register file.
REQ-009 MemW  input  1  decoder request to write memory.
REQ-010 NoWrite  input  1  compare-class instruction (CMP/CMN/TST/TEQ); suppresses register write.
REQ-011 Stall  input  1  hold: no flag update, write strobes forced 0.
REQ-012 Flush  input  1  kill current instruction: no flag update, write strobes forced 0.
REQ-013 PCSrc  output  1  gated PC write.
REQ-014 RegWrite  output  1  gated register write.
REQ-015 MemWrite  output  1  gated memory write.
REQ-016 CondEx  output  1  condition passed for current instruction.
REQ-017 Flags  output  4  registered NZCV.

Function
REQ-018 CondEx SHALL be combinational from Cond and registered Flags: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0.
REQ-019 Valid = CondEx & !Stall & !Flush & reset.
REQ-020 PCSrc = PCS & Valid; RegWrite = RegW & !NoWrite & Valid; MemWrite = MemW & Valid; all combinational, zero latency.
REQ-021 On rising clk with Valid=1 and FlagW[1]=1, Flags[3:2] SHALL load ALUFlags[3:2].
REQ-022 On rising clk with Valid=1 and FlagW[0]=1, Flags[1:0] SHALL load ALUFlags[1:0].
REQ-023 Flag halves SHALL update independently; unselected half holds.
REQ-024 Flag update SHALL use CondEx evaluated on pre-edge Flags; new flags affect CondEx from next cycle only (one-cycle latency, no bypass).
REQ-025 Stall or Flush SHALL block flag update regardless of FlagW; Flush and Stall together behave as Flush.
REQ-026 Instruction whose condition fails SHALL neither write flags nor assert any write strobe.
REQ-027 Flags SHALL be observable on the Flags port directly from the register.

Reset
REQ-028 reset low SHALL asynchronously set Flags=FLAGS_INIT, independent of clk.
REQ-029 While reset low, PCSrc, RegWrite, MemWrite SHALL be 0; CondEx reflects Cond against FLAGS_INIT.
REQ-030 Reset deassertion mid-operation SHALL resume with FLAGS_INIT; first flag update on first rising edge with reset high and Valid=1.

Verification
REQ-031 Reset, Cond=0000 -> CondEx=0, Flags=0000; Cond=0001 -> CondEx=1.
REQ-032 Cond=1110, FlagW=11, ALUFlags=0010 (SUB 5-2), edge -> Flags=0010; next cycle Cond=0010 CS -> CondEx=1, Cond=1000 HI -> CondEx=1.
REQ-033 Cond=1110, FlagW=11, ALUFlags=1000 (SUB 2-5), edge -> Flags=1000; Cond=1011 LT -> CondEx=1, RegW=1 -> RegWrite=1; Cond=1010 GE -> RegWrite=0.
REQ-034 Flags=1000, Cond=0000 EQ, FlagW=11, ALUFlags=0110 (SUB 5-5), edge -> Flags unchanged 1000, all strobes 0.
REQ-035 Cond=1110, FlagW=10, ALUFlags=0111 from Flags=1000 -> Flags=0100; then FlagW=01, ALUFlags=1010 -> Flags=0110.
REQ-036 Cond=1110, FlagW=11, PCS=MemW=1 with Stall=1, then Flush=1 -> strobes 0, Flags unchanged; reset pulse low mid-sequence -> Flags=0000 immediately.
